seq_shifter: RTL and testbench

SEQ_SHIFTER -- requirements
Module: seq_shifter

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_step.sv | 37 +++
 rtl/seq_shifter.sv | 120 ++++++++++++
 tb/tb_seq_shifter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the sequential shifter: FSM states and shift-mode encodings.
package shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_LOGICAL = 2'b00,
        MODE_ARITH   = 2'b01,
        MODE_ROTATE  = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: shifts value by k (0..STEP) in the requested
// direction and mode; reserved mode falls through to logical behaviour.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 2,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] value,
    input  logic [KW-1:0]    k,
    input  logic             dir,
    input  mode_e            mode,
    input  logic             fill,
    output logic [WIDTH-1:0] shifted
);

    localparam logic [WIDTH-1:0] ONES = '1;

    logic [WIDTH-1:0] fill_mask;

    always_comb begin
        // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
        fill_mask = ~(ONES >> k);
        shifted   = value;
        if (mode == MODE_ROTATE) begin
            // k is never WIDTH, and a shift by exactly WIDTH yields zero when k is 0.
            if (dir) shifted = (value >> k) | (value << (WIDTH - int'(k)));
            else     shifted = (value << k) | (value >> (WIDTH - int'(k)));
        end else if (dir) begin
            shifted = (value >> k) | ((mode == MODE_ARITH && fill) ? fill_mask : '0);
        end else begin
            shifted = value << k;
        end
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle barrel shifter: captures an operand on start, shifts at most STEP
// bits per cycle, then publishes the result on dout with a one-cycle done pulse.
module seq_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 2,
    localparam int AW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    amt,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    localparam int KW = $clog2(STEP + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [AW-1:0]    rem_q, rem_d;
    logic             dir_q, dir_d;
    mode_e            mode_q, mode_d;
    logic             fill_q, fill_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [KW-1:0]    k;
    logic [WIDTH-1:0] step_out;

    assign k = (int'(rem_q) > STEP) ? KW'(STEP) : KW'(rem_q);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .value   (work_q),
        .k       (k),
        .dir     (dir_q),
        .mode    (mode_q),
        .fill    (fill_q),
        .shifted (step_out)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        fill_d  = fill_q;
        dout_d  = dout_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d = din;
                    rem_d  = amt;
                    dir_d  = dir;
                    mode_d = mode_e'(mode);
                    fill_d = din[WIDTH-1];
                    if (amt == '0) begin
                        state_d = ST_DONE;
                        dout_d  = din;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = step_out;
                rem_d  = rem_q - AW'(k);
                if (rem_q == AW'(k)) begin
                    state_d = ST_DONE;
                    dout_d  = step_out;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Status flags are registered copies of the next state.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= MODE_LOGICAL;
            fill_q  <= 1'b0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter (WIDTH=8, STEP=2) with hand-computed results.
module tb_seq_shifter;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] din   = 8'h00;
    logic [2:0] amt   = 3'd0;
    logic       dir   = 1'b0;
    logic [1:0] mode  = 2'b00;
    logic       busy;
    logic       done;
    logic [7:0] dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_shifter #(.WIDTH(8), .STEP(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .din   (din),
        .amt   (amt),
        .dir   (dir),
        .mode  (mode),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One request; latency counts cycles from the start-sampling edge to done.
    task automatic run_op(input logic [7:0] d, input logic [2:0] a, input logic dr,
                          input logic [1:0] m, input logic [7:0] exp_dout,
                          input int exp_lat, input string tag);
        int lat;
        int busy_cnt;
        @(negedge clk);
        din = d; amt = a; dir = dr; mode = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; din = ~d; amt = ~a; dir = ~dr; mode = ~m;
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            busy_cnt += int'(busy);
            @(posedge clk); #1;
            lat++;
        end
        busy_cnt += int'(busy);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " dout"}, int'(dout), int'(exp_dout));
        check({tag, " busy cycles"}, busy_cnt, exp_lat);
        @(posedge clk); #1;
        check({tag, " done width"}, int'(done), 0);
        check({tag, " back to idle"}, int'(busy), 0);
        check({tag, " dout hold"}, int'(dout), int'(exp_dout));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int done_cnt;
        int done_at;

        #12;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset dout", int'(dout), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h3F, 3'd2, 1'b0, 2'b00, 8'hFC, 2, "lsl2");
        run_op(8'h92, 3'd3, 1'b1, 2'b01, 8'hF2, 3, "asr3");
        run_op(8'h92, 3'd5, 1'b0, 2'b10, 8'h52, 4, "rol5");
        run_op(8'hA5, 3'd0, 1'b0, 2'b00, 8'hA5, 1, "amt0");
        run_op(8'h81, 3'd1, 1'b1, 2'b11, 8'h40, 2, "rsvd_r1");
        run_op(8'h72, 3'd3, 1'b1, 2'b01, 8'h0E, 3, "asr3_pos");
        run_op(8'h81, 3'd1, 1'b1, 2'b10, 8'hC0, 2, "ror1");
        run_op(8'h80, 3'd7, 1'b1, 2'b00, 8'h01, 5, "lsr7");
        run_op(8'h81, 3'd1, 1'b0, 2'b01, 8'h02, 2, "asl1");
        run_op(8'h01, 3'd7, 1'b0, 2'b10, 8'h80, 5, "rol7");

        // start held high through SHIFT and DONE must neither restart nor queue.
        @(negedge clk);
        din = 8'h92; amt = 3'd5; dir = 1'b0; mode = 2'b10; start = 1'b1;
        @(posedge clk); #1;
        din = 8'hFF; amt = 3'd1; dir = 1'b1; mode = 2'b00;
        done_cnt = 0;
        done_at = 0;
        for (int i = 1; i <= 12; i++) begin
            if (i > 1) begin
                @(posedge clk); #1;
            end
            done_cnt += int'(done);
            if (done) done_at = i;
            if (i == 5) start = 1'b0;
        end
        check("busy start done count", done_cnt, 1);
        check("busy start done cycle", done_at, 4);
        check("busy start dout", int'(dout), 8'h52);
        check("busy start idle", int'(busy), 0);

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk);
        din = 8'h92; amt = 3'd5; dir = 1'b0; mode = 2'b10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("pre reset busy", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        check("async reset busy", int'(busy), 0);
        check("async reset done", int'(done), 0);
        check("async reset dout", int'(dout), 0);
        done_cnt = 0;
        repeat (3) begin
            @(posedge clk); #1;
            done_cnt += int'(done) + int'(busy);
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            done_cnt += int'(done) + int'(busy);
        end
        check("reset abort activity", done_cnt, 0);
        check("reset abort dout", int'(dout), 0);
        run_op(8'h3F, 3'd2, 1'b0, 2'b00, 8'hFC, 2, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
